// File: rtl/vga_timing_gen_if.sv
// DAC-side video bus: sync, blanking and 10-bit colour toward the ADV7123.
interface vga_timing_gen_if;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic       sync_n;
  logic [9:0] r;
  logic [9:0] g;
  logic [9:0] b;

  modport master (output hs, vs, blank_n, sync_n, r, g, b);
  modport slave  (input  hs, vs, blank_n, sync_n, r, g, b);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate VGA raster counters plus a one-stage registered DAC output that
// keeps sync, blanking and colour aligned to the coordinate of the prior cycle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [9:0]              i_red,
  input  logic [9:0]              i_green,
  input  logic [9:0]              i_blue,
  output logic [10:0]             o_x,
  output logic [10:0]             o_y,
  output logic                    o_frame_start,
  vga_timing_gen_if.master        vga
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned COL_W   = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, h_nxt;
  logic [CNT_W-1:0] v_cnt, v_nxt;
  logic             hs_q, hs_nxt;
  logic             vs_q, vs_nxt;
  logic             blank_n_q, blank_n_nxt;
  logic [COL_W-1:0] r_q, r_nxt;
  logic [COL_W-1:0] g_q, g_nxt;
  logic [COL_W-1:0] b_q, b_nxt;
  logic             visible_c;

  // Next counter position and the output-stage values for the current pixel.
  always_comb begin
    h_nxt       = h_cnt;
    v_nxt       = v_cnt;
    hs_nxt      = 1'b1;
    vs_nxt      = 1'b1;
    blank_n_nxt = 1'b0;
    r_nxt       = '0;
    g_nxt       = '0;
    b_nxt       = '0;
    visible_c   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

    if (!i_en) begin
      h_nxt = '0;
      v_nxt = '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_nxt = h_cnt + CNT_W'(1);
      end

      hs_nxt      = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
      vs_nxt      = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
      blank_n_nxt = visible_c;
      if (visible_c) begin
        r_nxt = i_red;
        g_nxt = i_green;
        b_nxt = i_blue;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      hs_q      <= hs_nxt;
      vs_q      <= vs_nxt;
      blank_n_q <= blank_n_nxt;
      r_q       <= r_nxt;
      g_q       <= g_nxt;
      b_q       <= b_nxt;
    end
  end

  // Frame start is combinational so the upstream generator sees it with (0,0).
  assign o_frame_start = (h_cnt == '0) && (v_cnt == '0) && i_en;
  assign o_x           = h_cnt;
  assign o_y           = v_cnt;
  assign vga.hs        = hs_q;
  assign vga.vs        = vs_q;
  assign vga.blank_n   = blank_n_q;
  assign vga.sync_n    = 1'b0;
  assign vga.r         = r_q;
  assign vga.g         = g_q;
  assign vga.b         = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a compact-timing
// instance, both checked every cycle against a frame-index reference model.
module tb_vga_timing_gen;

  localparam int ND = 2;

  int ha  [ND] = '{640, 16};
  int hfp [ND] = '{16, 4};
  int hsw [ND] = '{96, 6};
  int hbp [ND] = '{48, 4};
  int va  [ND] = '{480, 12};
  int vfp [ND] = '{10, 2};
  int vsw [ND] = '{2, 2};
  int vbp [ND] = '{33, 3};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  int          mode  = 0;
  logic [31:0] seed  = 32'd0;

  logic [10:0] x0, y0, x1, y1;
  logic        fs0, fs1;
  logic [9:0]  r0, g0, b0, r1, g1, b1;

  int n_chk  = 0;
  int n_fail = 0;

  vga_timing_gen_if dac0 ();
  vga_timing_gen_if dac1 ();

  vga_timing_gen u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_red(r0), .i_green(g0), .i_blue(b0),
    .o_x(x0), .o_y(y0), .o_frame_start(fs0), .vga(dac0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_red(r1), .i_green(g1), .i_blue(b1),
    .o_x(x1), .o_y(y1), .o_frame_start(fs1), .vga(dac1)
  );

  always #5 clk = ~clk;

  function automatic int htot(int d);
    return ha[d] + hfp[d] + hsw[d] + hbp[d];
  endfunction

  function automatic int vtot(int d);
    return va[d] + vfp[d] + vsw[d] + vbp[d];
  endfunction

  // Pattern generator: purely combinational in (x,y), shared by stimulus and model.
  function automatic logic [29:0] colour(int m, logic [31:0] s, int x, int y);
    logic [9:0] r, g, b;
    case (m)
      0: begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
      1: begin r = 10'(x); g = 10'(y); b = 10'(x + y); end
      default: begin
        r = 10'(x * 37 + y * 11 + int'(s[15:0]));
        g = 10'(x ^ int'(s[25:16]));
        b = 10'((y * 5) ^ int'(s[31:22]));
      end
    endcase
    return {r, g, b};
  endfunction

  always_comb {r0, g0, b0} = colour(mode, seed, int'(x0), int'(y0));
  always_comb {r1, g1, b1} = colour(mode, seed, int'(x1), int'(y1));

  // Reference model: linear position within the frame, decoded arithmetically.
  int          pos   [ND] = '{0, 0};
  logic        e_hs  [ND] = '{1'b1, 1'b1};
  logic        e_vs  [ND] = '{1'b1, 1'b1};
  logic        e_bl  [ND] = '{1'b0, 1'b0};
  logic [29:0] e_rgb [ND] = '{30'd0, 30'd0};
  int          mx, my;
  bit          mvis;

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n || !en) begin
        pos[d]   = 0;
        e_hs[d]  = 1'b1;
        e_vs[d]  = 1'b1;
        e_bl[d]  = 1'b0;
        e_rgb[d] = 30'd0;
      end else begin
        mx       = pos[d] % htot(d);
        my       = pos[d] / htot(d);
        mvis     = (mx < ha[d]) && (my < va[d]);
        e_hs[d]  = !((mx >= ha[d] + hfp[d]) && (mx < ha[d] + hfp[d] + hsw[d]));
        e_vs[d]  = !((my >= va[d] + vfp[d]) && (my < va[d] + vfp[d] + vsw[d]));
        e_bl[d]  = mvis;
        e_rgb[d] = mvis ? colour(mode, seed, mx, my) : 30'd0;
        pos[d]   = (pos[d] + 1) % (htot(d) * vtot(d));
      end
    end
  end

  function automatic logic [56:0] model_out(int d);
    return {11'(pos[d] % htot(d)), 11'(pos[d] / htot(d)), (pos[d] == 0) && en,
            e_hs[d], e_vs[d], e_bl[d], 1'b0, e_rgb[d]};
  endfunction

  function automatic logic [56:0] dut_out(int d);
    if (d == 0)
      return {x0, y0, fs0, dac0.hs, dac0.vs, dac0.blank_n, dac0.sync_n, dac0.r, dac0.g, dac0.b};
    return {x1, y1, fs1, dac1.hs, dac1.vs, dac1.blank_n, dac1.sync_n, dac1.r, dac1.g, dac1.b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int d = 0; d < ND; d++)
      chk($sformatf("model_dut%0d", d), 64'(dut_out(d)), 64'(model_out(d)));
  end

  typedef struct {
    int          k;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        hs;
    logic        bl;
    logic [9:0]  r;
  } vec_t;

  vec_t tv [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, vs_low, vs_first, hits, wait_cnt;
    int fs_at [$];
    logic [10:0] px0, px1;
    bit found;

    tv[0]  = '{0,    11'd0,   11'd0, 1'b1, 1'b1, 1'b0, 10'h000};
    tv[1]  = '{1,    11'd1,   11'd0, 1'b0, 1'b1, 1'b1, 10'h3FF};
    tv[2]  = '{639,  11'd639, 11'd0, 1'b0, 1'b1, 1'b1, 10'h3FF};
    tv[3]  = '{640,  11'd640, 11'd0, 1'b0, 1'b1, 1'b1, 10'h3FF};
    tv[4]  = '{641,  11'd641, 11'd0, 1'b0, 1'b1, 1'b0, 10'h000};
    tv[5]  = '{656,  11'd656, 11'd0, 1'b0, 1'b1, 1'b0, 10'h000};
    tv[6]  = '{657,  11'd657, 11'd0, 1'b0, 1'b0, 1'b0, 10'h000};
    tv[7]  = '{752,  11'd752, 11'd0, 1'b0, 1'b0, 1'b0, 10'h000};
    tv[8]  = '{753,  11'd753, 11'd0, 1'b0, 1'b1, 1'b0, 10'h000};
    tv[9]  = '{799,  11'd799, 11'd0, 1'b0, 1'b1, 1'b0, 10'h000};
    tv[10] = '{800,  11'd0,   11'd1, 1'b0, 1'b1, 1'b0, 10'h000};
    tv[11] = '{801,  11'd1,   11'd1, 1'b0, 1'b1, 1'b1, 10'h3FF};
    tv[12] = '{1600, 11'd0,   11'd2, 1'b0, 1'b1, 1'b0, 10'h000};
    tv[13] = '{1601, 11'd1,   11'd2, 1'b0, 1'b1, 1'b1, 10'h3FF};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_state0", 64'({x0, y0, dac0.hs, dac0.vs, dac0.blank_n, dac0.sync_n, dac0.r, dac0.g, dac0.b}),
        64'({11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 30'd0}));

    // Default-timing line walk from reset release, constant full-scale colour.
    rst_n = 1'b1;
    #2;
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      while (cyc < tv[i].k) begin
        @(posedge clk); #2;
        cyc++;
      end
      chk($sformatf("vec%0d_k%0d", i, tv[i].k),
          64'({x0, y0, fs0, dac0.hs, dac0.blank_n, dac0.r}),
          64'({tv[i].x, tv[i].y, tv[i].fs, tv[i].hs, tv[i].bl, tv[i].r}));
    end

    // Two compact frames: vsync window, (H_ACTIVE,V_ACTIVE) visits, frame period, alignment.
    @(negedge clk);
    rst_n = 1'b0;
    mode  = 1;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    vs_low = 0; vs_first = -1; hits = 0;
    px0 = '0; px1 = '0;
    for (int k = 0; k <= 1140; k++) begin
      if (!dac1.vs) begin
        if (k < 570) vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (k < 1140 && x1 == 11'd16 && y1 == 11'd12) hits++;
      if (fs1) fs_at.push_back(k);
      if (dac1.blank_n) chk("align1", 64'(dac1.r), 64'(px1[9:0]));
      if (dac0.blank_n) chk("align0", 64'(dac0.r), 64'(px0[9:0]));
      px0 = x0; px1 = x1;
      if (k < 1140) begin
        @(posedge clk); #2;
      end
    end
    chk("vs_first_cycle", 64'(vs_first), 64'd421);
    chk("vs_low_cycles", 64'(vs_low), 64'd60);
    chk("last_pixel_visits", 64'(hits), 64'd2);
    chk("frame_start_count", 64'(fs_at.size()), 64'd3);
    if (fs_at.size() == 3) begin
      chk("frame_period_a", 64'(fs_at[1] - fs_at[0]), 64'd570);
      chk("frame_period_b", 64'(fs_at[2] - fs_at[1]), 64'd570);
    end

    // Enable drop mid-frame at (10,5) for 10 cycles.
    found = 1'b0;
    for (wait_cnt = 0; wait_cnt < 1200 && !found; wait_cnt++) begin
      @(posedge clk); #2;
      if (x1 == 11'd10 && y1 == 11'd5) found = 1'b1;
    end
    chk("wait_x10_y5", 64'(found), 64'd1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #2;
    chk("en_drop", 64'({x1, y1, dac1.hs, dac1.vs, dac1.blank_n, dac1.r, dac1.g, dac1.b}),
        64'({11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 30'd0}));
    repeat (9) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    #2;
    chk("reenable_fs", 64'({fs0, fs1}), 64'b11);
    @(posedge clk); #2;
    chk("reenable_first", 64'({x1, y1, fs1, dac1.blank_n}), 64'({11'd1, 11'd0, 1'b0, 1'b1}));

    // Asynchronous reset while vsync is low.
    found = 1'b0;
    for (wait_cnt = 0; wait_cnt < 1200 && !found; wait_cnt++) begin
      @(posedge clk); #2;
      if (!dac1.vs) found = 1'b1;
    end
    chk("wait_vsync", 64'(found), 64'd1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({dac1.vs, dac1.blank_n, x1, y1}), 64'({1'b1, 1'b0, 11'd0, 11'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_reset_origin", 64'({x1, y1, fs1}), 64'({11'd0, 11'd0, 1'b1}));
    @(posedge clk); #2;
    chk("post_reset_step", 64'({x1, y1}), 64'({11'd1, 11'd0}));

    // Random enable windows, colour patterns and occasional resets.
    for (int seg = 0; seg < 30; seg++) begin
      @(negedge clk);
      mode = int'($urandom_range(0, 2));
      seed = $urandom;
      en   = 1'b1;
      repeat ($urandom_range(1, 1000)) @(negedge clk);
      en = 1'b0;
      repeat ($urandom_range(1, 12)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-rate VGA timing generator and DAC output stage for the 640x480 @ 60 Hz display path. It produces the pixel coordinates consumed by the pattern and colour generators. It samples their 10-bit RGB response and drives registered, mutually aligned hsync, vsync, blank and colour to the ADV7123 video DAC. i_clk is the 25.175 MHz (nominal 25 MHz) pixel clock from the PLL: one pixel per cycle, no clock enable.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- i_clk  in  1  pixel clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  run enable; low holds timing at origin with outputs blanked
- i_red, i_green, i_blue  in  10 each  colour for the pixel at current o_x/o_y (combinational from o_x/o_y)
- o_x  out  11  horizontal counter, 0..H_TOTAL-1
- o_y  out  11  vertical counter, 0..V_TOTAL-1
- o_frame_start  out  1  one-cycle pulse while o_x==0 and o_y==0
- o_vga_hs  out  1  hsync, active low
- o_vga_vs  out  1  vsync, active low
- o_vga_blank_n  out  1  high during visible pixels
- o_vga_sync_n  out  1  composite sync to DAC, constant 0
- o_vga_r, o_vga_g, o_vga_b  out  10 each  colour to DAC, zero when blanked

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤ 2047; counters are 11-bit unsigned.
- Line order: active, front porch, sync, back porch. The counter origin is the first visible pixel.
- h_cnt increments every cycle while i_en=1 and wraps H_TOTAL-1 -> 0.
- v_cnt increments only on the h_cnt wrap and wraps V_TOTAL-1 -> 0 on the same cycle h_cnt wraps.
- o_x = h_cnt and o_y = v_cnt, driven straight from the counter registers. Counters continue through blanking, so every (x,y) with x<H_TOTAL and y<V_TOTAL is presented for exactly one cycle per frame. In particular (640,480) occurs once per frame; downstream animation steps rely on this.
- Visible = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs_raw = 0 iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vs_raw = 0 iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync edges therefore coincide with the line boundary (h_cnt=0).
- Output stage registers, on the same edge: hs_raw, vs_raw, visible, and colour. Colour = visible ? i_rgb : 0.
- i_en=0: on the next edge the counters load 0 and hold. The output registers load hs=1, vs=1, blank_n=0, rgb=0, and o_frame_start=0.
- When i_en returns to 1, counting resumes from (0,0), starting a fresh frame with o_frame_start high on the first enabled cycle.
- Dropping i_en mid-frame truncates the frame; no partial-line completion.

## Timing
- Reset values: o_x=0, o_y=0, o_vga_hs=1, o_vga_vs=1, o_vga_blank_n=0, o_vga_r/g/b=0, o_vga_sync_n=0.
- o_frame_start is combinational (o_x==0 && o_y==0 && i_en). After reset release with i_en=1, it is high in the first cycle.
- Coordinate-to-DAC latency is exactly 1 cycle. The hs/vs/blank/colour presented at edge n+1 all belong to the o_x/o_y of cycle n.
- i_rgb must settle within the same cycle as o_x/o_y; the upstream generator is purely combinational.
- Line period H_TOTAL cycles; frame period H_TOTAL*V_TOTAL cycles (default 420000).
- hsync low width H_SYNC cycles; vsync low width V_SYNC*H_TOTAL cycles.
- Async reset mid-frame: all outputs take reset values immediately. Counting restarts at (0,0) on the first edge after deassertion.

## Test plan
- Reset release with i_en=1, defaults -> o_frame_start high cycle 0. o_vga_blank_n rises at edge 1 and stays high 640 cycles. hs falls 656 cycles after reset release (o_x=656 sampled), low 96 cycles. Line repeats every 800 cycles.
- Run one full frame -> vs low for exactly 1600 cycles, starting the cycle after (o_x=0,o_y=490). (640,480) seen exactly once. o_frame_start period 420000.
- Drive i_red=i_green=i_blue=10'h3FF constant -> DAC colour 10'h3FF only where blank_n=1, 0 elsewhere, including at o_x=640..799 and o_y≥480.
- Drive colour = {o_x[9:0]} -> at each visible edge, o_vga_r equals the previous cycle's o_x (checks 1-cycle alignment).
- Deassert i_en at o_x=300,o_y=200 for 10 cycles -> next edge o_x=o_y=0, hs=vs=1, blank_n=0, rgb=0. On re-enable, o_frame_start pulses and the timing matches a fresh frame.
- Assert i_rst_n=0 during vsync -> o_vga_vs=1 and blank_n=0 immediately (asynchronous). After release, the counters restart from 0.
